// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ROM default word, reset PC, opcodes and the
// fetch-stage types.
package mips_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOOP_WORD = 32'hFC00_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_NOOP  = 6'h3F;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t RUN  = 1'b0;
  localparam fetch_state_t HALT = 1'b1;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-stage bus: instruction ROM port, decode handshake, redirect and halt.
// if_valid/if_ready: a word transfers on any cycle both are high; while
// if_valid=1 and no transfer occurs, if_instr/if_pc hold steady.
interface instr_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_com;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, halted,
    input  imem_com, if_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, halted,
    output imem_com, if_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with a single-cycle flush.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction ROM, queues fetched
// words for decode, and handles redirects and end-of-program halt.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = mips_pkg::RESET_PC,
  parameter int          DEPTH        = 2,
  parameter logic [31:0] NOOP_WORD    = mips_pkg::NOOP_WORD,
  parameter bit          HALT_ON_NOOP = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_fetch_ctrl_if.master    bus,
  output mips_pkg::fetch_state_t dbg_state
);
  import mips_pkg::*;

  logic [31:0]  pc;
  fetch_state_t state;
  logic         push;
  logic         pop;
  logic         full;
  logic         empty;
  logic         hit_noop;
  fetch_entry_t head;
  fetch_entry_t din;
  logic         unused_rpc_lo;

  assign unused_rpc_lo = ^bus.redirect_pc[1:0];

  assign pop      = !empty && bus.if_ready;
  assign push     = (state == RUN) && !bus.redirect_valid && (!full || pop);
  assign hit_noop = HALT_ON_NOOP && (bus.imem_com == NOOP_WORD);
  assign din      = '{pc: pc, instr: bus.imem_com};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Redirect outranks both the +4 step and a halting NOOP fetched alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (bus.redirect_valid) begin
      pc    <= {bus.redirect_pc[31:2], 2'b00};
      state <= RUN;
    end else if (push) begin
      if (hit_noop) state <= HALT;
      else          pc    <= pc + 32'd4;
    end
  end

  assign bus.imem_addr = pc;
  assign bus.if_valid  = !empty;
  assign bus.if_instr  = empty ? 32'h0 : head.instr;
  assign bus.if_pc     = empty ? 32'h0 : head.pc;
  assign bus.halted    = (state == HALT) && empty;
  assign dbg_state     = state;

endmodule
